pipeline_inst_sequencer: RTL

- Owns the decode/execute/memory/writeback instruction registers of the 5-stage RISC-V pipeline and responds to hazard requests.
- The forwarding/hazard unit reads inst_decode..inst_writeback and raises STALL; this block receives STALL, branch flush and memory-busy, and decides whether to advance, hold, bubble or squash each stage.
- It also gates the PC.

---
 rtl/pipeline_inst_sequencer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_inst_sequencer.sv
// Instruction-register sequencer for the ID/EX/MEM/WB stages: advances, holds, bubbles or squashes on hazard requests and gates the PC.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_inst_sequencer #(
  parameter logic [31:0] NOP_INST  = 32'h00000013,
  parameter int          MAX_STALL = 4,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_fetch,
  input  logic             fetch_valid,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             mem_busy,
  output logic [31:0]      inst_decode,
  output logic [31:0]      inst_execute,
  output logic [31:0]      inst_memory,
  output logic [31:0]      inst_writeback,
  output logic [3:0]       stage_valid,
  output logic             pc_en,
  output logic [1:0]       state,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int SC_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ACT_ADV    = 3'd0,
    ACT_HOLD   = 3'd1,
    ACT_BUBBLE = 3'd2,
    ACT_FLUSH1 = 3'd3,
    ACT_FLUSH2 = 3'd4
  } act_t;

  state_t           state_r;
  state_t           state_nxt_s;
  act_t             act_s;
  logic             flush_pend_r;
  logic             pend_nxt_s;
  logic             timeout_set_s;
  logic [SC_W-1:0]  stall_cnt_r;
  logic [31:0]      inst_d_r;
  logic [31:0]      inst_e_r;
  logic [31:0]      inst_m_r;
  logic [31:0]      inst_w_r;
  logic [3:0]       valid_r;
  logic             stall_timeout_r;
  logic             pc_en_s;

  // Select this cycle's pipeline action and next state; priority mem_busy > flush > stall > advance.
  always_comb begin
    act_s         = ACT_ADV;
    state_nxt_s   = RUN;
    pend_nxt_s    = 1'b0;
    timeout_set_s = 1'b0;
    if (mem_busy) begin
      act_s       = ACT_HOLD;
      state_nxt_s = MEM_WAIT;
      // A freeze landing mid-flush must not lose the wrong-path squash.
      pend_nxt_s  = flush_pend_r | flush_req | (state_r == FLUSH);
    end else if (state_r == MEM_WAIT) begin
      if (flush_pend_r || flush_req) begin
        act_s       = ACT_FLUSH1;
        state_nxt_s = FLUSH;
      end else begin
        act_s       = ACT_ADV;
        state_nxt_s = RUN;
      end
    end else if (flush_req) begin
      act_s       = ACT_FLUSH1;
      state_nxt_s = FLUSH;
    end else if (state_r == FLUSH) begin
      act_s       = ACT_FLUSH2;
      state_nxt_s = RUN;
    end else if (stall_req) begin
      if (stall_cnt_r == SC_W'(MAX_STALL)) begin
        act_s         = ACT_ADV;
        state_nxt_s   = RUN;
        timeout_set_s = 1'b1;
      end else begin
        act_s       = ACT_BUBBLE;
        state_nxt_s = LU_STALL;
      end
    end else begin
      act_s       = ACT_ADV;
      state_nxt_s = RUN;
    end
  end

  // PC advance enable derived from the chosen action.
  always_comb begin
    pc_en_s = 1'b0;
    if (rst) begin
      pc_en_s = 1'b0;
    end else begin
      case (act_s)
        ACT_ADV:    pc_en_s = fetch_valid;
        ACT_FLUSH1: pc_en_s = 1'b1;
        ACT_FLUSH2: pc_en_s = 1'b1;
        default:    pc_en_s = 1'b0;
      endcase
    end
  end

  // Control state, pending flush, stall counter and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= RUN;
      flush_pend_r    <= 1'b0;
      stall_cnt_r     <= '0;
      stall_timeout_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      flush_pend_r <= pend_nxt_s;
      if (timeout_set_s) begin
        stall_timeout_r <= 1'b1;
      end else begin
        stall_timeout_r <= stall_timeout_r;
      end
      case (act_s)
        ACT_BUBBLE: stall_cnt_r <= stall_cnt_r + {{(SC_W-1){1'b0}}, 1'b1};
        ACT_HOLD:   stall_cnt_r <= stall_cnt_r;
        default:    stall_cnt_r <= '0;
      endcase
    end
  end

  // Instruction registers and valid bits, {W,M,E,D} ordering for valid_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_d_r <= NOP_INST;
      inst_e_r <= NOP_INST;
      inst_m_r <= NOP_INST;
      inst_w_r <= NOP_INST;
      valid_r  <= 4'b0000;
    end else begin
      case (act_s)
        ACT_ADV: begin
          inst_w_r <= inst_m_r;
          inst_m_r <= inst_e_r;
          inst_e_r <= inst_d_r;
          inst_d_r <= fetch_valid ? inst_fetch : NOP_INST;
          valid_r  <= {valid_r[2:0], fetch_valid};
        end
        ACT_BUBBLE: begin
          inst_w_r <= inst_m_r;
          inst_m_r <= inst_e_r;
          inst_e_r <= NOP_INST;
          valid_r  <= {valid_r[2], valid_r[1], 1'b0, valid_r[0]};
        end
        ACT_FLUSH1: begin
          inst_w_r <= inst_m_r;
          inst_m_r <= inst_e_r;
          inst_e_r <= NOP_INST;
          inst_d_r <= NOP_INST;
          valid_r  <= {valid_r[2], valid_r[1], 2'b00};
        end
        ACT_FLUSH2: begin
          inst_w_r <= inst_m_r;
          inst_m_r <= inst_e_r;
          inst_e_r <= inst_d_r;
          inst_d_r <= NOP_INST;
          valid_r  <= {valid_r[2:0], 1'b0};
        end
        default: begin
          inst_d_r <= inst_d_r;
          inst_e_r <= inst_e_r;
          inst_m_r <= inst_m_r;
          inst_w_r <= inst_w_r;
          valid_r  <= valid_r;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             flush_acc_s;

  // A request merged into an already-pending flush is the same event.
  assign flush_acc_s = flush_req & ~flush_pend_r;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_r <= '0;
      flush_cnt_r  <= '0;
    end else begin
      if ((act_s == ACT_BUBBLE) && (bubble_cnt_r != {CNT_W{1'b1}})) begin
        bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
      if (flush_acc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;
`else
  assign bubble_cnt = {CNT_W{1'b0}};
  assign flush_cnt  = {CNT_W{1'b0}};
`endif

  assign inst_decode    = inst_d_r;
  assign inst_execute   = inst_e_r;
  assign inst_memory    = inst_m_r;
  assign inst_writeback = inst_w_r;
  assign stage_valid    = valid_r;
  assign state          = state_r;
  assign stall_timeout  = stall_timeout_r;
  assign pc_en          = pc_en_s;

endmodule
